// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm
//   Miss-handling stage in front of the cache tag/metadata and data arrays.
//   On a miss it fetches one aligned block from a pipelined main memory:
//   it issues one word request per cycle, streams each returned word into
//   the data array, and writes the metadata byte together with the last
//   word so that the next lookup hits.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   miss_detected         lookup missed (level, held until the fill is done)
//   miss_address          byte address of the missing access
//   memory_data_valid     memory returns one word this cycle
//   memory_data           returned word
//   mem_en / mem_addr     word read request and its byte address
//   data_we               write one word into the data array
//   fill_word_idx         word slot within the block for data_we
//   data_out              word to write (memory_data while data_we, else 0)
//   meta_we / meta_out    metadata write, meta_out = {valid=1, lru=0, tag}
//   fsm_busy              fill in progress; stalls the pipeline
//   fill_done             one-cycle pulse, same cycle as meta_we
//   fill_count            (FILL_PERF_CNT_EN only) saturating count of fills
//
// Build option
//   FILL_PERF_CNT_EN  adds the fill_count port and its counter.
//
// Handshake: there is no backpressure in either direction. A request is
// issued every cycle that mem_en is 1, and a returned word is consumed on
// every cycle memory_data_valid is 1 while a fill is in progress; words
// arriving while idle are dropped. Every output is combinational from the
// registered state and the current inputs, and is 0 unless its strobe is
// active.
module cache_fill_fsm #(
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int INDEX_W         = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  input  logic                               memory_data_valid,
  input  logic [15:0]                        memory_data,
  output logic                               mem_en,
  output logic [ADDR_W-1:0]                  mem_addr,
  output logic                               data_we,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_idx,
  output logic [15:0]                        data_out,
  output logic                               meta_we,
  output logic [7:0]                         meta_out,
  output logic                               fsm_busy,
  output logic                               fill_done
`ifdef FILL_PERF_CNT_EN
  ,
  output logic [15:0]                        fill_count
`endif
);

  localparam int OFF_W = $clog2(WORDS_PER_BLOCK * 2);
  localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = IDX_W + 1;
  localparam int BLK_W = ADDR_W - OFF_W;

  localparam logic [CNT_W-1:0] ISSUE_END = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [IDX_W-1:0] RECV_LAST = IDX_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] issue_cnt;   // requests issued so far, 0..WORDS_PER_BLOCK
  logic [IDX_W-1:0] recv_cnt;    // words received so far
  logic [BLK_W-1:0] base_blk;    // block address, offset bits implied zero
  logic [TAG_W-1:0] base_tag;

  assign base_tag = base_blk[BLK_W-1:INDEX_W];

  // State and datapath registers. The base is latched only when a fill
  // starts, so miss_address changes during a fill have no effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      base_blk  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (miss_detected) begin
          base_blk  <= miss_address[ADDR_W-1:OFF_W];
          issue_cnt <= '0;
          recv_cnt  <= '0;
        end
      end else begin
        if (mem_en) begin
          issue_cnt <= issue_cnt + CNT_W'(1);
        end
        if (data_we) begin
          recv_cnt <= recv_cnt + IDX_W'(1);
        end
      end
    end
  end

  // Next state and outputs.
  always_comb begin
    state_nxt     = state;
    mem_en        = 1'b0;
    mem_addr      = '0;
    data_we       = 1'b0;
    fill_word_idx = '0;
    data_out      = '0;
    meta_we       = 1'b0;
    meta_out      = '0;
    fsm_busy      = 1'b0;
    fill_done     = 1'b0;

    if (state == IDLE) begin
      if (miss_detected) begin
        state_nxt = FILL;
      end
    end else begin
      fsm_busy = 1'b1;
      // Requests go out back to back in the first cycles of the fill.
      if (issue_cnt < ISSUE_END) begin
        mem_en   = 1'b1;
        mem_addr = {base_blk, OFF_W'(0)} + ADDR_W'({issue_cnt, 1'b0});
      end
      // Returned words arrive in request order, so the receive count is
      // the word slot; gaps in valid simply pause it.
      if (memory_data_valid) begin
        data_we       = 1'b1;
        fill_word_idx = recv_cnt;
        data_out      = memory_data;
        if (recv_cnt == RECV_LAST) begin
          meta_we   = 1'b1;
          meta_out  = 8'({1'b1, 1'b0, base_tag});
          fill_done = 1'b1;
          state_nxt = IDLE;
        end
      end
    end
  end

`ifdef FILL_PERF_CNT_EN
  // Completed-fill counter; an aborted fill never pulses fill_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_count <= '0;
    end else if (fill_done && (fill_count != 16'hFFFF)) begin
      fill_count <= fill_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Testbench for cache_fill_fsm: a fixed vector table for the first fill,
// then directed multi-cycle sequences and random traffic checked against a
// transaction-level reference model with a latency-4 memory model.
module tb_cache_fill_fsm;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        data_we;
  logic [2:0]  fill_word_idx;
  logic [15:0] data_out;
  logic        meta_we;
  logic [7:0]  meta_out;
  logic        fsm_busy;
  logic        fill_done;
`ifdef FILL_PERF_CNT_EN
  logic [15:0] fill_count;
`endif

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .mem_en            (mem_en),
    .mem_addr          (mem_addr),
    .data_we           (data_we),
    .fill_word_idx     (fill_word_idx),
    .data_out          (data_out),
    .meta_we           (meta_we),
    .meta_out          (meta_out),
    .fsm_busy          (fsm_busy),
    .fill_done         (fill_done)
`ifdef FILL_PERF_CNT_EN
    ,
    .fill_count        (fill_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic compare_outs(input string tag, input logic e_busy, input logic e_en,
                              input logic [15:0] e_addr, input logic e_we, input logic [2:0] e_idx,
                              input logic [15:0] e_dout, input logic e_mwe, input logic [7:0] e_mout,
                              input logic e_done);
    check({tag, ".busy"},  32'(fsm_busy),      32'(e_busy));
    check({tag, ".en"},    32'(mem_en),        32'(e_en));
    check({tag, ".addr"},  32'(mem_addr),      32'(e_addr));
    check({tag, ".we"},    32'(data_we),       32'(e_we));
    check({tag, ".idx"},   32'(fill_word_idx), 32'(e_idx));
    check({tag, ".dout"},  32'(data_out),      32'(e_dout));
    check({tag, ".mwe"},   32'(meta_we),       32'(e_mwe));
    check({tag, ".mout"},  32'(meta_out),      32'(e_mout));
    check({tag, ".done"},  32'(fill_done),     32'(e_done));
  endtask

  // Memory model: every request returns its word 4 cycles later, in order.
  typedef struct {
    logic [15:0] data;
    int          ready;
  } ret_t;
  ret_t mem_q[$];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Reference model: a fill is a list of expected request addresses and a
  // list of word slots still to be written.
  logic        m_busy;
  logic [15:0] exp_q[$];
  logic [2:0]  idx_q[$];
  logic [5:0]  m_tag;
  int          m_fills;

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_tag   = 6'h0;
    m_fills = 0;
    exp_q.delete();
    idx_q.delete();
  endfunction

  function automatic void model_step(input logic miss, input logic [15:0] addr, input logic vld);
    logic [15:0] blk;
    if (!m_busy) begin
      if (miss) begin
        m_busy = 1'b1;
        blk    = addr & 16'hFFF0;
        exp_q.delete();
        idx_q.delete();
        for (int i = 0; i < 8; i++) begin
          exp_q.push_back(blk + 16'(2 * i));
          idx_q.push_back(3'(i));
        end
        m_tag = addr[15:10];
      end
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (vld && idx_q.size() > 0) begin
        void'(idx_q.pop_front());
        if (idx_q.size() == 0) begin
          m_busy = 1'b0;
          if (m_fills < 65535) m_fills++;
        end
      end
    end
  endfunction

  // Driver: one cycle of stimulus, check at negedge, model update at posedge.
  task automatic drive_cycle(input logic miss, input logic [15:0] addr, input int gap_mode,
                             input logic spurious);
    logic        gap_ok;
    logic        popped;
    logic        e_en, e_we, e_last;
    logic [15:0] e_addr, e_dout;
    logic [2:0]  e_idx;
    logic [7:0]  e_mout;
    popped = 1'b0;
    case (gap_mode)
      0:       gap_ok = 1'b1;
      1:       gap_ok = (cyc % 3 == 0);
      default: gap_ok = 1'($urandom_range(0, 1));
    endcase
    miss_detected = miss;
    miss_address  = addr;
    if (mem_q.size() > 0 && mem_q[0].ready <= cyc && gap_ok) begin
      memory_data_valid = 1'b1;
      memory_data       = mem_q[0].data;
      popped            = 1'b1;
    end else if (spurious && !m_busy && mem_q.size() == 0) begin
      memory_data_valid = 1'b1;
      memory_data       = 16'($urandom);
    end else begin
      memory_data_valid = 1'b0;
      memory_data       = 16'($urandom);
    end
    @(negedge clk);
    e_en   = m_busy && (exp_q.size() > 0);
    e_addr = e_en ? exp_q[0] : 16'h0;
    e_we   = m_busy && memory_data_valid && (idx_q.size() > 0);
    e_idx  = e_we ? idx_q[0] : 3'd0;
    e_dout = e_we ? memory_data : 16'h0;
    e_last = e_we && (idx_q.size() == 1);
    e_mout = e_last ? {2'b10, m_tag} : 8'h0;
    compare_outs("mdl", m_busy, e_en, e_addr, e_we, e_idx, e_dout, e_last, e_mout, e_last);
`ifdef FILL_PERF_CNT_EN
    check("mdl.fill_count", 32'(fill_count), 32'(m_fills));
`endif
    if (mem_en) mem_q.push_back('{mem_word(mem_addr), cyc + 4});
    if (popped) void'(mem_q.pop_front());
    @(posedge clk);
    model_step(miss, addr, memory_data_valid);
    cyc++;
    #1;
  endtask

  task automatic run_until_idle(input logic miss, input logic [15:0] addr, input int gap_mode,
                                input string name);
    int n;
    n = 0;
    while (m_busy && n < 200) begin
      drive_cycle(miss, addr, gap_mode, 1'b0);
      n++;
    end
    check({name, ".fill_finished"}, 32'(m_busy), 32'(0));
  endtask

  // Vector table for the first fill (data words driven directly).
  typedef struct {
    logic        miss;
    logic [15:0] addr;
    logic        vld;
    logic [15:0] vdata;
    logic        busy;
    logic        en;
    logic [15:0] maddr;
    logic        we;
    logic [2:0]  idx;
    logic [15:0] dout;
    logic        mwe;
    logic [7:0]  mout;
    logic        done;
  } vec_t;
  vec_t tbl[16];

  initial begin
    int n;
    logic popped;

    tbl[0]  = '{1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 16'h5678, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1230, 1'b0, 3'd0, 16'h0000, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 16'h5678, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1232, 1'b0, 3'd0, 16'h0000, 1'b0, 8'h00, 1'b0};
    tbl[4]  = '{1'b1, 16'h9ABC, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0, 3'd0, 16'h0000, 1'b0, 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 16'h9ABC, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1236, 1'b0, 3'd0, 16'h0000, 1'b0, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 16'h9ABC, 1'b1, 16'hD000, 1'b1, 1'b1, 16'h1238, 1'b1, 3'd0, 16'hD000, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{1'b1, 16'h9ABC, 1'b1, 16'hD001, 1'b1, 1'b1, 16'h123A, 1'b1, 3'd1, 16'hD001, 1'b0, 8'h00, 1'b0};
    tbl[8]  = '{1'b0, 16'h9ABC, 1'b1, 16'hD002, 1'b1, 1'b1, 16'h123C, 1'b1, 3'd2, 16'hD002, 1'b0, 8'h00, 1'b0};
    tbl[9]  = '{1'b0, 16'h9ABC, 1'b1, 16'hD003, 1'b1, 1'b1, 16'h123E, 1'b1, 3'd3, 16'hD003, 1'b0, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 16'h9ABC, 1'b1, 16'hD004, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd4, 16'hD004, 1'b0, 8'h00, 1'b0};
    tbl[11] = '{1'b0, 16'h9ABC, 1'b1, 16'hD005, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd5, 16'hD005, 1'b0, 8'h00, 1'b0};
    tbl[12] = '{1'b0, 16'h9ABC, 1'b1, 16'hD006, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd6, 16'hD006, 1'b0, 8'h00, 1'b0};
    tbl[13] = '{1'b0, 16'h9ABC, 1'b1, 16'hD007, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd7, 16'hD007, 1'b1, 8'h84, 1'b1};
    tbl[14] = '{1'b0, 16'h9ABC, 1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 8'h00, 1'b0};
    tbl[15] = '{1'b0, 16'h9ABC, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 8'h00, 1'b0};

    // Reset: outputs must be 0 while reset is held.
    model_reset();
    rst               = 1'b1;
    miss_detected     = 1'b0;
    miss_address      = 16'h0;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_outs("reset", 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 8'h0, 1'b0);
`ifdef FILL_PERF_CNT_EN
    check("reset.fill_count", 32'(fill_count), 32'(0));
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First fill from the vector table.
    for (int i = 0; i < 16; i++) begin
      miss_detected     = tbl[i].miss;
      miss_address      = tbl[i].addr;
      memory_data_valid = tbl[i].vld;
      memory_data       = tbl[i].vdata;
      @(negedge clk);
      compare_outs($sformatf("tbl%0d", i), tbl[i].busy, tbl[i].en, tbl[i].maddr, tbl[i].we,
                   tbl[i].idx, tbl[i].dout, tbl[i].mwe, tbl[i].mout, tbl[i].done);
      @(posedge clk);
      cyc++;
      #1;
    end
    m_fills = 1;

    // Gapped valid pattern 1,0,0,...
    drive_cycle(1'b1, 16'h7F16, 1, 1'b0);
    run_until_idle(1'b0, 16'h0000, 1, "gap");

    // Spurious valid pulses while idle.
    for (int i = 0; i < 6; i++) drive_cycle(1'b0, 16'($urandom), 0, 1'b1);

    // Miss held across two addresses; addresses seen during the fill are
    // random and must be ignored, the second base is taken in the idle cycle.
    drive_cycle(1'b1, 16'h2468, 0, 1'b0);
    n = 0;
    while (m_busy && n < 200) begin
      drive_cycle(1'b1, 16'($urandom), 0, 1'b0);
      n++;
    end
    check("b2b.first_finished", 32'(m_busy), 32'(0));
    drive_cycle(1'b1, 16'hFEDC, 0, 1'b0);
    check("b2b.second_started", 32'(fsm_busy), 32'(1));
    check("b2b.second_base", 32'(mem_addr), 32'(16'hFED0));
    run_until_idle(1'b1, 16'hFEDC, 0, "b2b");
    miss_detected = 1'b0;
    drive_cycle(1'b0, 16'h0, 0, 1'b0);

    // Reset after the 3rd returned word of a fill.
    drive_cycle(1'b1, 16'h4A7E, 0, 1'b0);
    n = 0;
    while (idx_q.size() > 5 && n < 40) begin
      drive_cycle(1'b0, 16'h4A7E, 0, 1'b0);
      n++;
    end
    check("rst_mid.three_words", 32'(idx_q.size()), 32'(5));
    rst           = 1'b1;
    miss_detected = 1'b0;
    popped        = 1'b0;
    if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
      memory_data_valid = 1'b1;
      memory_data       = mem_q[0].data;
      popped            = 1'b1;
    end else begin
      memory_data_valid = 1'b0;
    end
    @(negedge clk);
    compare_outs("rst_mid", 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 8'h0, 1'b0);
`ifdef FILL_PERF_CNT_EN
    check("rst_mid.fill_count", 32'(fill_count), 32'(0));
`endif
    if (popped) void'(mem_q.pop_front());
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    model_reset();
    n = 0;
    while (mem_q.size() > 0 && n < 40) begin
      drive_cycle(1'b0, 16'h0, 0, 1'b0);
      n++;
    end
    check("rst_mid.drained", 32'(mem_q.size()), 32'(0));

    // Three complete fills after the reset.
    for (int f = 0; f < 3; f++) begin
      drive_cycle(1'b1, 16'(16'h0C08 + 16'(f * 16'h1110)), 0, 1'b0);
      run_until_idle(1'b0, 16'h0, 2, "post_rst");
    end
`ifdef FILL_PERF_CNT_EN
    check("perf.three_fills", 32'(fill_count), 32'(3));
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive_cycle(1'($urandom_range(0, 3) == 0), 16'($urandom), 2, 1'($urandom_range(0, 1)));
    end
    run_until_idle(1'b0, 16'h0, 2, "random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
